// File: rtl/psu_pkg.sv
// ============================================================================
// Module      : psu_pkg
// Description : Shared mode encodings and FSM state type for param_shift_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package psu_pkg;

  localparam logic [2:0] MODE_SRL = 3'b000;
  localparam logic [2:0] MODE_SLL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } psu_state_t;

  // Codes above MODE_ROL are hold modes: the burst runs but data is frozen.
  function automatic logic mode_moves(input logic [2:0] m);
    return (m <= MODE_ROL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/psu_shift_step.sv
// ============================================================================
// Module      : psu_shift_step
// Description : Combinational single-step shifter (STEP bits) for all modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psu_shift_step
  import psu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       mode,
  input  logic [STEP-1:0]  ser_in,
  output logic [WIDTH-1:0] next_d,
  output logic [STEP-1:0]  ejected
);

  always_comb begin
    next_d  = d;
    ejected = d[STEP-1:0];
    case (mode)
      MODE_SRL: next_d = {ser_in, d[WIDTH-1:STEP]};
      MODE_SLL: begin
        next_d  = {d[WIDTH-1-STEP:0], ser_in};
        ejected = d[WIDTH-1:WIDTH-STEP];
      end
      MODE_SRA: next_d = {{STEP{d[WIDTH-1]}}, d[WIDTH-1:STEP]};
      MODE_ROR: next_d = {d[STEP-1:0], d[WIDTH-1:STEP]};
      MODE_ROL: begin
        next_d  = {d[WIDTH-1-STEP:0], d[WIDTH-1:WIDTH-STEP]};
        ejected = d[WIDTH-1:WIDTH-STEP];
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/param_shift_unit.sv
// ============================================================================
// Module      : param_shift_unit
// Description : Multi-mode burst shift engine with load and start/busy/done.
//               Define PSU_PARITY_EN to register XOR parity of data_out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_shift_unit
  import psu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [STEP-1:0]  ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic [STEP-1:0]  ser_out,
  output logic             busy,
  output logic             done,
  output logic             parity
);

  psu_state_t       r_state;
  psu_state_t       w_state_next;
  logic [WIDTH-1:0] r_data;
  logic [STEP-1:0]  r_ser_out;
  logic [CNT_W-1:0] r_remaining;
  logic [2:0]       r_mode;
  logic [WIDTH-1:0] w_step_d;
  logic [STEP-1:0]  w_step_ej;
  logic             w_shift_moves;
  logic             w_data_we;
  logic [WIDTH-1:0] w_data_d;

  psu_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .d       (r_data),
    .mode    (r_mode),
    .ser_in  (ser_in),
    .next_d  (w_step_d),
    .ejected (w_step_ej)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!load && start)
          w_state_next = (count != '0) ? SHIFT : FIN;
      end
      SHIFT: begin
        busy = 1'b1;
        if (load)
          w_state_next = IDLE;
        else if (r_remaining <= CNT_W'(1))
          w_state_next = FIN;
      end
      FIN: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_shift_moves = (r_state == SHIFT) && !load && mode_moves(r_mode);
  assign w_data_we     = load || w_shift_moves;
  assign w_data_d      = load ? data_in : w_step_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data      <= '0;
      r_ser_out   <= '0;
      r_remaining <= '0;
      r_mode      <= MODE_SRL;
    end else begin
      if (w_data_we)
        r_data <= w_data_d;
      if (w_shift_moves)
        r_ser_out <= w_step_ej;
      if (load) begin
        r_remaining <= '0;
      end else if (r_state == IDLE && start) begin
        r_remaining <= count;
        r_mode      <= mode;
      end else if (r_state == SHIFT) begin
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  assign data_out = r_data;
  assign ser_out  = r_ser_out;

`ifdef PSU_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_parity <= 1'b0;
    else if (w_data_we) r_parity <= ^w_data_d;
  end

  assign parity = r_parity;
`else
  assign parity = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_shift_unit.sv
// ============================================================================
// Module      : tb_param_shift_unit
// Description : Randomised self-checking bench for param_shift_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_shift_unit;

  localparam int W  = 16;
  localparam int S  = 1;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [W-1:0]  data_in;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] count;
  logic [S-1:0]  ser_in;
  logic [W-1:0]  data_out;
  logic [S-1:0]  ser_out;
  logic          busy;
  logic          done;
  logic          parity;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_data;
  logic [S-1:0] m_ser;

  param_shift_unit #(.WIDTH(W), .STEP(S), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in),
    .start    (start),
    .mode     (mode),
    .count    (count),
    .ser_in   (ser_in),
    .data_out (data_out),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done),
    .parity   (parity)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_parity();
`ifdef PSU_PARITY_EN
    return ^m_data;
`else
    return 1'b0;
`endif
  endfunction

  // Reference one-step behaviour, written as plain arithmetic on the value.
  function automatic void model_step(input logic [2:0] md, input logic [S-1:0] s);
    logic [W-1:0] d;
    d = m_data;
    case (md)
      3'd0: begin m_ser = S'(d % (1 << S)); m_data = (d >> S) | (W'(s) << (W - S)); end
      3'd1: begin m_ser = S'(d >> (W - S)); m_data = (d << S) | W'(s); end
      3'd2: begin m_ser = S'(d % (1 << S)); m_data = W'($signed(d) >>> S); end
      3'd3: begin m_ser = S'(d % (1 << S)); m_data = (d >> S) | (d << (W - S)); end
      3'd4: begin m_ser = S'(d >> (W - S)); m_data = (d << S) | (d >> (W - S)); end
      default: ;
    endcase
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, "_data"},   32'(data_out), 32'(m_data));
    check_eq({tag, "_ser"},    32'(ser_out),  32'(m_ser));
    check_eq({tag, "_parity"}, 32'(parity),   32'(exp_parity()));
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; data_in = v;
    tick();
    load = 1'b0; m_data = v;
    check_state("load");
    check_eq("load_busy", 32'(busy), 32'd0);
  endtask

  // One burst: start accept, cnt shift cycles, FIN; optional abort by load.
  task automatic burst(input logic [2:0] md, input int cnt, input bit rand_ser,
                       input bit start_hold, input int abort_at,
                       input logic [W-1:0] abort_val, input bit load_fin);
    logic [S-1:0] s;
    logic [W-1:0] v;
    start = 1'b1; mode = md; count = CW'(cnt);
    tick();
    if (!start_hold) start = 1'b0;
    mode  = 3'($urandom);
    count = CW'($urandom);
    for (int i = 0; i < cnt; i++) begin
      check_eq("busy_in_shift", 32'(busy), 32'd1);
      check_eq("done_in_shift", 32'(done), 32'd0);
      if (i == abort_at) begin
        start = 1'b0; load = 1'b1; data_in = abort_val;
        tick();
        load = 1'b0; m_data = abort_val;
        check_state("abort");
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        tick();
        check_eq("abort_done2", 32'(done), 32'd0);
        check_eq("abort_busy2", 32'(busy), 32'd0);
        return;
      end
      s = rand_ser ? S'($urandom) : '0;
      ser_in = s;
      model_step(md, s);
      tick();
      check_state("shift");
    end
    start = 1'b0;
    check_eq("fin_done", 32'(done), 32'd1);
    check_eq("fin_busy", 32'(busy), 32'd0);
    if (load_fin) begin
      v = W'($urandom);
      load = 1'b1; data_in = v;
      tick();
      load = 1'b0; m_data = v;
    end else begin
      tick();
    end
    check_state("post");
    check_eq("post_done", 32'(done), 32'd0);
    check_eq("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = '0; start = 1'b0;
    mode = '0; count = '0; ser_in = '0;
    m_data = '0; m_ser = '0;
    #1;
    check_state("reset");
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // SRL of 0xA5C3 by 4, zero fill: ejects 1,1,0,0
    do_load(16'hA5C3);
    burst(3'd0, 4, 1'b0, 1'b0, -1, '0, 1'b0);
    check_eq("t2_final", 32'(data_out), 32'h0A5C);

    do_load(16'h8001);
    burst(3'd2, 3, 1'b0, 1'b0, -1, '0, 1'b0);
    check_eq("t3_final", 32'(data_out), 32'hF000);

    do_load(16'h8001);
    burst(3'd4, 1, 1'b0, 1'b0, -1, '0, 1'b0);
    check_eq("t4_rol1", 32'(data_out), 32'h0003);
    do_load(16'h8001);
    burst(3'd4, 16, 1'b0, 1'b0, -1, '0, 1'b0);
    check_eq("t4_rol16", 32'(data_out), 32'h8001);

    // count 0, then a burst with start held high throughout
    burst(3'd1, 0, 1'b1, 1'b0, -1, '0, 1'b0);
    burst(3'd3, 5, 1'b0, 1'b1, -1, '0, 1'b0);

    do_load(16'h00FF);
    burst(3'd1, 8, 1'b0, 1'b0, 2, 16'h1234, 1'b0);
`ifdef PSU_PARITY_EN
    check_eq("t6_parity", 32'(parity), 32'd1);
`endif

    // hold mode: counts down, data and ser_out frozen
    burst(3'd6, 3, 1'b1, 1'b0, -1, '0, 1'b1);

    // simultaneous load+start in idle loads only
    load = 1'b1; start = 1'b1; data_in = 16'hBEEF; mode = 3'd0; count = 8'd3;
    tick();
    load = 1'b0; start = 1'b0; m_data = 16'hBEEF;
    check_state("ldst");
    check_eq("ldst_busy", 32'(busy), 32'd0);
    check_eq("ldst_done", 32'(done), 32'd0);
    tick();
    check_eq("ldst_busy2", 32'(busy), 32'd0);

    for (int k = 0; k < 60; k++) begin
      do_load(W'($urandom));
      burst(3'($urandom), int'($urandom_range(0, 20)), 1'b1,
            1'($urandom), ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1,
            W'($urandom), 1'($urandom));
    end

    // asynchronous reset in the middle of a cycle during a burst
    do_load(16'hFFFF);
    start = 1'b1; mode = 3'd0; count = 8'd10; ser_in = '0;
    tick();
    start = 1'b0;
    tick();
    #3 rst = 1'b1;
    #1;
    m_data = '0; m_ser = '0;
    check_state("async_rst");
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("after_rst_done", 32'(done), 32'd0);
    check_state("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
